// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Built-in self-check for a divided clock. The divided clock is treated as
// asynchronous data, passed through a three-flop synchronizer, and each full
// rise-to-rise period is measured in clk_in cycles. Every completed period
// reports its length and high-sample count. Sticky flags record a period
// mismatch, a duty count outside the legal window, and a stuck clock.
module clk_div_monitor #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned EXP_PERIOD   = 7,
    parameter int unsigned EXP_HIGH_MIN = 3,
    parameter int unsigned EXP_HIGH_MAX = 4,
    parameter int unsigned TIMEOUT      = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             en,
    input  logic             clear_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             err_period,
    output logic             err_duty,
    output logic             err_stuck
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EXP_PERIOD_C = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] HIGH_MIN_C   = CNT_W'(EXP_HIGH_MIN);
    localparam logic [CNT_W-1:0] HIGH_MAX_C   = CNT_W'(EXP_HIGH_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);

    // Saturating increment: a counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // True when a high count lies outside the legal duty window.
    function automatic logic duty_out_of_range(input logic [CNT_W-1:0] value);
        return (value < HIGH_MIN_C) || (value > HIGH_MAX_C);
    endfunction

    // Synchronizer stages
    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Measurement state
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] pcnt_d;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] hcnt_d;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0] idle_cnt_d;

    // Registered outputs
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] high_cnt_d;
    logic             meas_valid_q;
    logic             meas_valid_d;
    logic             err_period_q;
    logic             err_period_d;
    logic             err_duty_q;
    logic             err_duty_d;
    logic             err_stuck_q;
    logic             err_stuck_d;

    // Combinational helpers
    logic             rise_s;
    logic             fall_s;
    logic             timeout_s;
    logic [CNT_W-1:0] pcnt_inc_s;
    logic [CNT_W-1:0] hcnt_inc_s;
    logic [CNT_W-1:0] idle_inc_s;
    logic             ev_period_s;
    logic             ev_duty_s;
    logic             ev_stuck_s;

    // Three-flop synchronizer for the asynchronous divided clock.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_div;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge detection and the candidate next values of the counters.
    always_comb begin
        rise_s     = s2_q & ~s3_q;
        fall_s     = ~s2_q & s3_q;
        pcnt_inc_s = sat_inc(pcnt_q);
        hcnt_inc_s = s2_q ? sat_inc(hcnt_q) : hcnt_q;
        // idle_cnt never exceeds TIMEOUT-1, so this add cannot overflow.
        idle_inc_s = idle_cnt_q + CNT_ONE;
        timeout_s  = (idle_inc_s == TIMEOUT_C) && !(rise_s || fall_s);
    end

    // Measurement FSM next state, counters and per-period capture.
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        hcnt_d       = hcnt_q;
        idle_cnt_d   = idle_cnt_q;
        period_d     = period_q;
        high_cnt_d   = high_cnt_q;
        meas_valid_d = 1'b0;
        ev_period_s  = 1'b0;
        ev_duty_s    = 1'b0;
        ev_stuck_s   = 1'b0;

        if (!en) begin
            // Disabling abandons any partial period; results are kept.
            state_d    = ST_IDLE;
            pcnt_d     = CNT_ZERO;
            hcnt_d     = CNT_ZERO;
            idle_cnt_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ARM;
                    pcnt_d     = CNT_ZERO;
                    hcnt_d     = CNT_ZERO;
                    idle_cnt_d = CNT_ZERO;
                end
                ST_ARM: begin
                    if (rise_s) begin
                        // First rise only opens a measurement window.
                        state_d    = ST_MEAS;
                        pcnt_d     = CNT_ONE;
                        hcnt_d     = CNT_ONE;
                        idle_cnt_d = CNT_ZERO;
                    end else if (fall_s) begin
                        idle_cnt_d = CNT_ZERO;
                    end else if (timeout_s) begin
                        ev_stuck_s = 1'b1;
                        state_d    = ST_ARM;
                        pcnt_d     = CNT_ZERO;
                        hcnt_d     = CNT_ZERO;
                        idle_cnt_d = CNT_ZERO;
                    end else begin
                        idle_cnt_d = idle_inc_s;
                    end
                end
                ST_MEAS: begin
                    if (rise_s) begin
                        // Close the current period and start the next one.
                        period_d     = pcnt_q;
                        high_cnt_d   = hcnt_q;
                        meas_valid_d = 1'b1;
                        ev_period_s  = (pcnt_q != EXP_PERIOD_C);
                        ev_duty_s    = duty_out_of_range(hcnt_q);
                        pcnt_d       = CNT_ONE;
                        hcnt_d       = CNT_ONE;
                        idle_cnt_d   = CNT_ZERO;
                    end else if (fall_s) begin
                        pcnt_d     = pcnt_inc_s;
                        hcnt_d     = hcnt_inc_s;
                        idle_cnt_d = CNT_ZERO;
                    end else if (timeout_s) begin
                        // Stuck clock: drop the partial period and re-arm.
                        ev_stuck_s = 1'b1;
                        state_d    = ST_ARM;
                        pcnt_d     = CNT_ZERO;
                        hcnt_d     = CNT_ZERO;
                        idle_cnt_d = CNT_ZERO;
                    end else begin
                        pcnt_d     = pcnt_inc_s;
                        hcnt_d     = hcnt_inc_s;
                        idle_cnt_d = idle_inc_s;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    pcnt_d     = CNT_ZERO;
                    hcnt_d     = CNT_ZERO;
                    idle_cnt_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Sticky error flags: a new event wins over a simultaneous clear.
    always_comb begin
        if (ev_period_s) begin
            err_period_d = 1'b1;
        end else if (clear_err) begin
            err_period_d = 1'b0;
        end else begin
            err_period_d = err_period_q;
        end

        if (ev_duty_s) begin
            err_duty_d = 1'b1;
        end else if (clear_err) begin
            err_duty_d = 1'b0;
        end else begin
            err_duty_d = err_duty_q;
        end

        if (ev_stuck_s) begin
            err_stuck_d = 1'b1;
        end else if (clear_err) begin
            err_stuck_d = 1'b0;
        end else begin
            err_stuck_d = err_stuck_q;
        end
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pcnt_q       <= CNT_ZERO;
            hcnt_q       <= CNT_ZERO;
            idle_cnt_q   <= CNT_ZERO;
            period_q     <= CNT_ZERO;
            high_cnt_q   <= CNT_ZERO;
            meas_valid_q <= 1'b0;
            err_period_q <= 1'b0;
            err_duty_q   <= 1'b0;
            err_stuck_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            hcnt_q       <= hcnt_d;
            idle_cnt_q   <= idle_cnt_d;
            period_q     <= period_d;
            high_cnt_q   <= high_cnt_d;
            meas_valid_q <= meas_valid_d;
            err_period_q <= err_period_d;
            err_duty_q   <= err_duty_d;
            err_stuck_q  <= err_stuck_d;
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_cnt_q;
    assign meas_valid = meas_valid_q;
    assign err_period = err_period_q;
    assign err_duty   = err_duty_q;
    assign err_stuck  = err_stuck_q;

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Period and duty-cycle checker for a divided clock produced by the odd/even clock dividers, running in the source clock domain. It samples the divided clock through a synchronizer and measures each full period in `clk_in` cycles. Per period it reports period length and high time, and flags period mismatch, duty out of range, and stuck-clock conditions. It sits directly downstream of a divider such as the divide-by-7 50%-duty stage, as a built-in self-check.

## Interface
- `CNT_W`, 8: width of period/high counters and outputs.
- `EXP_PERIOD`, 7: expected period in `clk_in` cycles.
- `EXP_HIGH_MIN`, 3: minimum legal high count per period.
- `EXP_HIGH_MAX`, 4: maximum legal high count per period.
- `TIMEOUT`, 32: cycles without a detected edge before a stuck error; must be < 2^CNT_W.
- `clk_in` input 1: sole clock, all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `clk_div` input 1: divided clock under test; treated as asynchronous data.
- `en` input 1: monitor enable, level.
- `clear_err` input 1: one-cycle pulse; clears sticky error flags.
- `period` output CNT_W: last measured period.
- `high_cnt` output CNT_W: high-sample count of last period.
- `meas_valid` output 1: one-cycle pulse when `period`/`high_cnt` update.
- `err_period` output 1: sticky; a measured period ≠ EXP_PERIOD.
- `err_duty` output 1: sticky; high_cnt outside [EXP_HIGH_MIN, EXP_HIGH_MAX].
- `err_stuck` output 1: sticky; no edge for TIMEOUT cycles while measuring.

## Operation
- Synchronizer: `s1 <= clk_div; s2 <= s1; s3 <= s2`. rise = s2 & ~s3, fall = ~s2 & s3. All flops reset to 0.
- FSM states: IDLE, ARM, MEAS.
  - IDLE: counters held at 0. `en`=1 → ARM.
  - ARM: wait for the first rise. On rise → MEAS; `pcnt` loads 1; `hcnt` loads 1.
  - MEAS: `pcnt` increments every cycle; `hcnt` increments when s2=1.
- On rise in MEAS:
  - `period` <= `pcnt`; `high_cnt` <= `hcnt`; `meas_valid` pulses.
  - Error checks run on the captured values.
  - `pcnt` reloads 1 and `hcnt` reloads 1, restarting the measurement.
- The first partial period after ARM is never reported.
- Stuck detection uses `idle_cnt`, which is cleared on any rise or fall and otherwise increments in ARM and MEAS.
  - When `idle_cnt` reaches TIMEOUT: `err_stuck` sets, FSM → ARM, counters cleared, no `meas_valid`.
- Counter widths: `pcnt`/`hcnt` saturate at 2^CNT_W−1 and never wrap.
- `en`=0 in any state → IDLE next cycle. Counters and `idle_cnt` are cleared. `period`, `high_cnt` and error flags hold their values.
- `clear_err` clears all three flags. If an error event occurs in the same cycle as `clear_err`, that flag is set.
- Reset forces all outputs to 0 and the FSM to IDLE, including reset during MEAS.

## Timing
- Synchronizer latency: a `clk_div` rising transition sampled at edge N gives rise=1 during the cycle after edge N+1.
- `meas_valid`, `period` and `high_cnt` are registered. They update at the clock edge ending the rise cycle, so the latency is 3 `clk_in` edges after the `clk_div` transition is sampled.
- Error flags assert in the same cycle as the `meas_valid` that reports the offending value.
- `err_stuck` asserts on the edge where `idle_cnt` reaches TIMEOUT.
- `meas_valid` cannot pulse on consecutive cycles; the minimum detectable period is 2.
- Back-to-back legal periods produce one `meas_valid` every EXP_PERIOD cycles.

## Test plan
- Nominal period: reset, en=1, drive `clk_div` synchronously as 4 high / 3 low cycles, repeating.
  - First `meas_valid` appears after the second rise, with `period`=7 and `high_cnt`=4.
  - Subsequent pulses every 7 cycles; all err flags stay 0.
- Wrong period: pattern 4 high / 4 low → `period`=8 and `err_period`=1 on that `meas_valid`.
  - `err_period` stays 1 after the pattern returns to 4/3.
- Bad duty: pattern 6 high / 1 low → `period`=7, `high_cnt`=6, `err_duty`=1, `err_period`=0.
- Stuck clock: `clk_div` held 1 for 40 cycles while in MEAS → `err_stuck`=1 on the 32nd cycle without an edge.
  - No `meas_valid` while stuck.
  - After toggling resumes, the first report comes two rises later.
- Clear vs. new error: pulse `clear_err` in the same cycle as a `meas_valid` reporting period 8 → `err_period` remains 1.
  - Pulse `clear_err` alone later → all flags 0 on the next cycle.
- Disable and reset mid-measure:
  - Drop `en` mid-period → no `meas_valid`; `period` holds 7. Re-enable → the first report comes after two rises.
  - Assert `rst`=0 mid-period → all outputs 0 at the next edge.
